// File: rtl/syrup_mem_arbiter.sv
// Round-robin arbiter sharing one single-port Syrup memory among NUM_PORTS requesters,
// with registered memory commands, a per-port lock and fixed-latency read-return routing.
module syrup_mem_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [NUM_PORTS-1:0]             REQ,
    input  logic [NUM_PORTS-1:0]             WE,
    input  logic [NUM_PORTS-1:0]             LOCK,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  ADDR,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  D,
    input  logic [NUM_PORTS*BE_WIDTH-1:0]    BE,
    output logic [NUM_PORTS-1:0]             GNT,
    output logic [NUM_PORTS-1:0]             RVALID,
    output logic [DATA_WIDTH-1:0]            RDATA,
    output logic [ADDR_WIDTH-1:0]            MEM_ADDR,
    output logic [DATA_WIDTH-1:0]            MEM_D,
    output logic                             MEM_WE,
    output logic                             MEM_RE,
    output logic [BE_WIDTH-1:0]              MEM_BE,
    input  logic [DATA_WIDTH-1:0]            MEM_Q
);

    localparam int PW = $clog2(NUM_PORTS);

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } lock_state_t;

    lock_state_t            r_state;
    lock_state_t            w_stateNext;
    logic [PW-1:0]          r_ptr;
    logic [PW-1:0]          r_owner;

    logic                   w_gntValid;
    logic [PW-1:0]          w_gntIdx;
    logic [PW-1:0]          w_scanPort;
    logic [PW-1:0]          w_ptrNext;
    int                     w_scanIdx;

    logic [ADDR_WIDTH-1:0]  w_selAddr;
    logic [DATA_WIDTH-1:0]  w_selD;
    logic [BE_WIDTH-1:0]    w_selBe;
    logic                   w_selWe;

    logic [ADDR_WIDTH-1:0]  r_memAddr;
    logic [DATA_WIDTH-1:0]  r_memD;
    logic [BE_WIDTH-1:0]    r_memBe;
    logic                   r_memWe;
    logic                   r_memRe;
    logic [PW-1:0]          r_memPort;

    logic                   r_tagValid [RD_LATENCY];
    logic [PW-1:0]          r_tagId    [RD_LATENCY];

    // Scan from the pointer downward so the lowest offset from PTR wins; a held lock bypasses the scan.
    always_comb begin
        w_gntValid = 1'b0;
        w_gntIdx   = '0;
        w_scanIdx  = 0;
        w_scanPort = '0;
        if (!RST) begin
            if (r_state == ST_LOCKED) begin
                if (REQ[r_owner]) begin
                    w_gntValid = 1'b1;
                    w_gntIdx   = r_owner;
                end
            end else begin
                for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                    w_scanIdx = int'(r_ptr) + k;
                    if (w_scanIdx >= NUM_PORTS) begin
                        w_scanIdx = w_scanIdx - NUM_PORTS;
                    end
                    w_scanPort = PW'(w_scanIdx);
                    if (REQ[w_scanPort]) begin
                        w_gntValid = 1'b1;
                        w_gntIdx   = w_scanPort;
                    end
                end
            end
        end
    end

    always_comb begin
        GNT = '0;
        if (w_gntValid) begin
            GNT[w_gntIdx] = 1'b1;
        end
    end

    always_comb begin
        w_selAddr = '0;
        w_selD    = '0;
        w_selBe   = '0;
        w_selWe   = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_gntIdx == PW'(p)) begin
                w_selAddr = ADDR[p*ADDR_WIDTH +: ADDR_WIDTH];
                w_selD    = D[p*DATA_WIDTH +: DATA_WIDTH];
                w_selBe   = BE[p*BE_WIDTH +: BE_WIDTH];
                w_selWe   = WE[p];
            end
        end
    end

    // The locked owner is the only eligible port, so advancing PTR on every grant equals advancing on release.
    assign w_ptrNext = (w_gntIdx == PW'(NUM_PORTS - 1)) ? '0 : w_gntIdx + 1'b1;

    always_comb begin
        w_stateNext = r_state;
        if (w_gntValid) begin
            w_stateNext = LOCK[w_gntIdx] ? ST_LOCKED : ST_OPEN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_OPEN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr     <= '0;
            r_owner   <= '0;
            r_memAddr <= '0;
            r_memD    <= '0;
            r_memBe   <= '0;
            r_memWe   <= 1'b0;
            r_memRe   <= 1'b0;
            r_memPort <= '0;
        end else if (w_gntValid) begin
            r_ptr     <= w_ptrNext;
            r_owner   <= w_gntIdx;
            r_memAddr <= w_selAddr;
            r_memD    <= w_selD;
            r_memBe   <= w_selBe;
            r_memWe   <= w_selWe;
            r_memRe   <= ~w_selWe;
            r_memPort <= w_gntIdx;
        end else begin
            r_memWe   <= 1'b0;
            r_memRe   <= 1'b0;
        end
    end

    // Stage k holds the issuing port of the read that was on the memory bus k+1 cycles ago.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_tagValid[i] <= 1'b0;
                r_tagId[i]    <= '0;
            end
        end else begin
            r_tagValid[0] <= r_memRe;
            r_tagId[0]    <= r_memPort;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tagValid[i] <= r_tagValid[i-1];
                r_tagId[i]    <= r_tagId[i-1];
            end
        end
    end

    always_comb begin
        RVALID = '0;
        if (!RST && r_tagValid[RD_LATENCY-1]) begin
            RVALID[r_tagId[RD_LATENCY-1]] = 1'b1;
        end
    end

    assign RDATA    = MEM_Q;
    assign MEM_ADDR = r_memAddr;
    assign MEM_D    = r_memD;
    assign MEM_BE   = r_memBe;
    assign MEM_WE   = r_memWe;
    assign MEM_RE   = r_memRe;

endmodule

// File: tb/tb_syrup_mem_arbiter.sv
// Self-checking bench for syrup_mem_arbiter: directed scenarios with literal expectations,
// randomized traffic, and a transaction-level model compared against the DUT every cycle.
module tb_syrup_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int RL = 1;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [N-1:0]    REQ, WE, LOCK;
    logic [N*AW-1:0] ADDR;
    logic [N*DW-1:0] D;
    logic [N*BW-1:0] BE;
    logic [N-1:0]    GNT, RVALID;
    logic [DW-1:0]   RDATA;
    logic [AW-1:0]   MEM_ADDR;
    logic [DW-1:0]   MEM_D;
    logic            MEM_WE, MEM_RE;
    logic [BW-1:0]   MEM_BE;
    logic [DW-1:0]   MEM_Q;

    logic            reqA  [N];
    logic            weA   [N];
    logic            lockA [N];
    logic [AW-1:0]   addrA [N];
    logic [DW-1:0]   dA    [N];
    logic [BW-1:0]   beA   [N];

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    syrup_mem_arbiter #(
        .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .RD_LATENCY(RL)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .LOCK(LOCK), .ADDR(ADDR), .D(D), .BE(BE),
        .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA), .MEM_ADDR(MEM_ADDR), .MEM_D(MEM_D),
        .MEM_WE(MEM_WE), .MEM_RE(MEM_RE), .MEM_BE(MEM_BE), .MEM_Q(MEM_Q)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        for (int p = 0; p < N; p++) begin
            REQ[p]             = reqA[p];
            WE[p]              = weA[p];
            LOCK[p]            = lockA[p];
            ADDR[p*AW +: AW]   = addrA[p];
            D[p*DW +: DW]      = dA[p];
            BE[p*BW +: BW]     = beA[p];
        end
    end

    function automatic logic [DW-1:0] initVal(int a);
        return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [DW-1:0] applyBe(logic [DW-1:0] old, logic [DW-1:0] nv, logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) r[b*8 +: 8] = nv[b*8 +: 8];
        end
        return r;
    endfunction

    // Memory stub: word-per-address storage, Q valid RL cycles after a cycle with RE.
    logic [DW-1:0] stubMem [int];
    logic [DW-1:0] qPipe   [RL];

    function automatic logic [DW-1:0] stubRead(int a);
        return stubMem.exists(a) ? stubMem[a] : initVal(a);
    endfunction

    always @(posedge CLK) begin
        if (MEM_WE) stubMem[int'(MEM_ADDR)] = applyBe(stubRead(int'(MEM_ADDR)), MEM_D, MEM_BE);
        for (int i = RL - 1; i > 0; i--) qPipe[i] <= qPipe[i-1];
        qPipe[0] <= MEM_RE ? stubRead(int'(MEM_ADDR)) : '0;
    end
    assign MEM_Q = qPipe[RL-1];

    // Reference model: expected memory contents in grant order plus a list of owed read returns.
    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] shadow [int];
    rd_t           pend [$];
    int            mPtr    = 0;
    bit            mLocked = 1'b0;
    int            mOwner  = 0;
    logic [AW-1:0] eAddr   = '0;
    logic [DW-1:0] eD      = '0;
    logic [BW-1:0] eBe     = '0;
    logic          eWe     = 1'b0;
    logic          eRe     = 1'b0;

    function automatic logic [DW-1:0] shadowRead(int a);
        return shadow.exists(a) ? shadow[a] : initVal(a);
    endfunction

    function automatic void preload(int a, logic [DW-1:0] v);
        stubMem[a] = v;
        shadow[a]  = v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cycle, act, exp);
        end
    endtask

    always @(negedge CLK) begin : modelProc
        logic [N-1:0]  expGnt;
        logic [N-1:0]  expRv;
        logic [DW-1:0] expRd;
        int            g;
        int            a;
        cycle++;
        g = -1;
        if (!RST) begin
            if (mLocked) begin
                if (reqA[mOwner]) g = mOwner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && reqA[(mPtr + k) % N]) g = (mPtr + k) % N;
                end
            end
        end
        expGnt = (g >= 0) ? (N'(1) << g) : '0;
        expRv  = '0;
        expRd  = '0;
        if (!RST) begin
            foreach (pend[i]) begin
                if (pend[i].due == cycle) begin
                    expRv = N'(1) << pend[i].port;
                    expRd = pend[i].data;
                end
            end
        end
        checkOutput("gnt", GNT, expGnt);
        checkOutput("mem_we", MEM_WE, eWe);
        checkOutput("mem_re", MEM_RE, eRe);
        checkOutput("mem_addr", MEM_ADDR, eAddr);
        checkOutput("mem_d", MEM_D, eD);
        checkOutput("mem_be", MEM_BE, eBe);
        checkOutput("rvalid", RVALID, expRv);
        if (expRv != '0) checkOutput("rdata", RDATA, expRd);

        if (RST) begin
            mPtr    = 0;
            mLocked = 1'b0;
            pend.delete();
            eAddr = '0; eD = '0; eBe = '0; eWe = 1'b0; eRe = 1'b0;
        end else begin
            while (pend.size() > 0 && pend[0].due <= cycle) void'(pend.pop_front());
            eWe = 1'b0;
            eRe = 1'b0;
            if (g >= 0) begin
                a     = int'(addrA[g]);
                eAddr = addrA[g];
                eD    = dA[g];
                eBe   = beA[g];
                eWe   = weA[g];
                eRe   = !weA[g];
                if (weA[g]) shadow[a] = applyBe(shadowRead(a), dA[g], beA[g]);
                else        pend.push_back('{cycle + 1 + RL, g, shadowRead(a)});
                if (lockA[g]) begin
                    mLocked = 1'b1;
                    mOwner  = g;
                end else begin
                    mLocked = 1'b0;
                    mPtr    = (g + 1) % N;
                end
            end
        end
    end

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic setPort(input int p, input logic req, input logic we, input logic lock,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        reqA[p] = req; weA[p] = we; lockA[p] = lock; addrA[p] = a; dA[p] = d; beA[p] = be;
    endtask

    task automatic clearPorts();
        for (int p = 0; p < N; p++) setPort(p, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin : stimulus
        logic [N-1:0]  g, rv, lastG;
        logic [DW-1:0] rd;
        logic [AW-1:0] chaseAddr, p1Addr;
        logic [DW-1:0] chaseExp [3];
        int            hops;
        bit            issue;

        clearPorts();
        for (int p = 0; p < N; p++) setPort(p, 1'b1, 1'b0, 1'b0, AW'(p * 4), '0, '0);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("rst_gnt", GNT, 4'b0000);
        checkOutput("rst_mem_re", MEM_RE, 1'b0);
        applyStimulus(1);
        @(negedge CLK);
        checkOutput("rst_mem_addr", MEM_ADDR, 24'h0);
        preload(32'h10, 32'h0000_CAFE);
        preload(32'h00, 32'd5);
        preload(32'h18, 32'd7);
        preload(32'h20, 32'h0000_1234);

        // Single read by port 1
        applyStimulus(1);
        RST = 1'b0;
        clearPorts();
        setPort(1, 1'b1, 1'b0, 1'b0, 24'h10, '0, '0);
        @(negedge CLK);
        checkOutput("single_gnt", GNT, 4'b0010);
        applyStimulus(1);
        clearPorts();
        @(negedge CLK);
        checkOutput("single_mem_re", MEM_RE, 1'b1);
        checkOutput("single_mem_addr", MEM_ADDR, 24'h10);
        applyStimulus(1);
        @(negedge CLK);
        checkOutput("single_rvalid", RVALID, 4'b0010);
        checkOutput("single_rdata", RDATA, 32'h0000_CAFE);

        // All ports requesting continuously from reset
        applyStimulus(1);
        RST = 1'b1;
        applyStimulus(1);
        RST = 1'b0;
        for (int p = 0; p < N; p++) setPort(p, 1'b1, 1'b0, 1'b0, AW'(32'h80 + p * 4), '0, '0);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            checkOutput("rr_gnt", GNT, N'(1) << (i % N));
            if (i >= 1) checkOutput("rr_mem_re", MEM_RE, 1'b1);
            if (i >= 2) checkOutput("rr_rvalid", RVALID, N'(1) << ((i - 2) % N));
            applyStimulus(1);
        end
        clearPorts();
        applyStimulus(3);

        // Write then read the same address from port 0
        setPort(0, 1'b1, 1'b1, 1'b0, 24'h40, 32'hDEAD_BEEF, 4'hF);
        @(negedge CLK);
        checkOutput("wr_gnt", GNT, 4'b0001);
        applyStimulus(1);
        setPort(0, 1'b1, 1'b0, 1'b0, 24'h40, '0, '0);
        @(negedge CLK);
        checkOutput("wr_mem_we", MEM_WE, 1'b1);
        checkOutput("wr_mem_d", MEM_D, 32'hDEAD_BEEF);
        checkOutput("wr_mem_be", MEM_BE, 4'hF);
        checkOutput("wr_no_rvalid", RVALID, 4'b0000);
        applyStimulus(1);
        clearPorts();
        @(negedge CLK);
        checkOutput("rd_mem_re", MEM_RE, 1'b1);
        checkOutput("wr_no_rvalid2", RVALID, 4'b0000);
        applyStimulus(1);
        @(negedge CLK);
        checkOutput("rd_rvalid", RVALID, 4'b0001);
        checkOutput("rd_rdata", RDATA, 32'hDEAD_BEEF);
        applyStimulus(1);

        // Lock held by port 2 while port 0 keeps requesting
        setPort(0, 1'b1, 1'b1, 1'b0, 24'h300, 32'h1111_2222, 4'h3);
        setPort(2, 1'b1, 1'b0, 1'b1, 24'h10, '0, '0);
        @(negedge CLK);
        checkOutput("lock_gnt0", GNT, 4'b0100);
        applyStimulus(1);
        setPort(2, 1'b0, 1'b0, 1'b0, 24'h0, '0, '0);
        @(negedge CLK);
        checkOutput("lock_idle_owner", GNT, 4'b0000);
        applyStimulus(1);
        setPort(2, 1'b1, 1'b0, 1'b1, 24'h18, '0, '0);
        @(negedge CLK);
        checkOutput("lock_gnt1", GNT, 4'b0100);
        applyStimulus(1);
        setPort(2, 1'b1, 1'b0, 1'b0, 24'h20, '0, '0);
        @(negedge CLK);
        checkOutput("lock_release_gnt", GNT, 4'b0100);
        applyStimulus(1);
        setPort(2, 1'b0, 1'b0, 1'b0, 24'h0, '0, '0);
        @(negedge CLK);
        checkOutput("lock_after_gnt", GNT, 4'b0001);
        applyStimulus(1);
        clearPorts();
        applyStimulus(3);

        // Pointer chase on port 3 with port 1 streaming writes
        chaseExp[0] = 32'd5;
        chaseExp[1] = 32'd7;
        chaseExp[2] = 32'h0000_1234;
        chaseAddr = 24'h0;
        p1Addr    = 24'h200;
        hops      = 0;
        issue     = 1'b1;
        for (int c = 0; c < 60 && hops < 3; c++) begin
            setPort(3, issue, 1'b0, 1'b0, chaseAddr, '0, '0);
            setPort(1, 1'b1, 1'b1, 1'b0, p1Addr, DW'($urandom), 4'hF);
            @(negedge CLK);
            g  = GNT;
            rv = RVALID;
            rd = RDATA;
            if (g[3]) issue = 1'b0;
            if (g[1]) p1Addr = p1Addr + 24'd4;
            if (rv[3]) begin
                checkOutput("chase_data", rd, chaseExp[hops]);
                chaseAddr = AW'((rd + 32'd1) << 2);
                hops++;
                issue = 1'b1;
            end
            applyStimulus(1);
        end
        if (hops < 3) checkOutput("chase_timeout", hops, 3);
        clearPorts();
        applyStimulus(3);

        // Randomized traffic; requests are held until granted
        lastG = '0;
        for (int c = 0; c < 400; c++) begin
            RST = ($urandom_range(0, 79) == 0);
            for (int p = 0; p < N; p++) begin
                if (!reqA[p] || lastG[p]) begin
                    setPort(p, $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
                            $urandom_range(0, 5) == 0, AW'($urandom_range(0, 15) * 4),
                            DW'($urandom), BW'($urandom));
                end
            end
            @(negedge CLK);
            lastG = GNT;
            applyStimulus(1);
        end

        // Reset while a read is in flight
        clearPorts();
        RST = 1'b1;
        applyStimulus(2);
        RST = 1'b0;
        setPort(2, 1'b1, 1'b0, 1'b0, 24'h10, '0, '0);
        @(negedge CLK);
        checkOutput("rstrd_gnt", GNT, 4'b0100);
        applyStimulus(1);
        clearPorts();
        @(negedge CLK);
        checkOutput("rstrd_mem_re", MEM_RE, 1'b1);
        applyStimulus(1);
        RST = 1'b1;
        for (int p = 0; p < N; p++) setPort(p, 1'b1, 1'b0, 1'b0, AW'(p * 8), '0, '0);
        @(negedge CLK);
        checkOutput("rstrd_rvalid", RVALID, 4'b0000);
        checkOutput("rstrd_gnt_rst", GNT, 4'b0000);
        applyStimulus(1);
        @(negedge CLK);
        checkOutput("rstrd_mem_re0", MEM_RE, 1'b0);
        checkOutput("rstrd_mem_addr0", MEM_ADDR, 24'h0);
        checkOutput("rstrd_mem_d0", MEM_D, 32'h0);
        checkOutput("rstrd_mem_be0", MEM_BE, 4'h0);
        applyStimulus(1);
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("rstrd_first_gnt", GNT, 4'b0001);
        checkOutput("rstrd_rvalid_after", RVALID, 4'b0000);
        applyStimulus(1);
        clearPorts();
        applyStimulus(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/syrup_mem_arbiter.md
Name: syrup_mem_arbiter

Overview:
- Round-robin arbiter sharing one single-port Syrup memory (SyrupMemory1P-style ADDR/D/WE/RE/Q/BE interface) among NUM_PORTS user-logic requesters.
- Accepts one read or write command per cycle and drives registered memory commands.
- Tracks fixed-latency read returns and routes Q back to the issuing port with a per-port valid pulse.
- Supports a per-port LOCK so a requester can hold the memory for dependent sequences (pointer chase, read-modify-write).

Parameters:
- NUM_PORTS, 4, number of requesters (2..16).
- ADDR_WIDTH, 24, memory byte-address width.
- DATA_WIDTH, 32, data width.
- BE_WIDTH, 4, byte-enable width (DATA_WIDTH/8).
- RD_LATENCY, 1, cycles from a cycle with MEM_RE=1 to the cycle MEM_Q is valid (1..4).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- REQ  in  NUM_PORTS  per-port request; held until granted.
- WE  in  NUM_PORTS  per-port write (1) / read (0) select.
- LOCK  in  NUM_PORTS  per-port lock request, sampled with a granted request.
- ADDR  in  NUM_PORTS*ADDR_WIDTH  flattened addresses; port i uses slice i.
- D  in  NUM_PORTS*DATA_WIDTH  flattened write data.
- BE  in  NUM_PORTS*BE_WIDTH  flattened byte enables.
- GNT  out  NUM_PORTS  one-hot grant; combinational, same cycle as acceptance.
- RVALID  out  NUM_PORTS  one-hot read-return pulse.
- RDATA  out  DATA_WIDTH  read data (MEM_Q, broadcast); valid where RVALID is set.
- MEM_ADDR  out  ADDR_WIDTH  to memory ADDR.
- MEM_D  out  DATA_WIDTH  to memory D.
- MEM_WE  out  1  to memory WE.
- MEM_RE  out  1  to memory RE.
- MEM_BE  out  BE_WIDTH  to memory BE.
- MEM_Q  in  DATA_WIDTH  from memory Q.

Behaviour:
- Reset (RST=1 at a clock edge): MEM_ADDR, MEM_D, MEM_BE = 0; MEM_WE, MEM_RE = 0; RVALID = 0; return-tag pipeline cleared (reads in flight are dropped, no RVALID); PTR = 0; lock cleared. GNT = 0 while RST=1.
- Arbitration, combinational each cycle, no lock held:
  - Scan ports PTR, PTR+1, ... modulo NUM_PORTS.
  - First port with REQ=1 gets GNT; at most one GNT bit is set.
  - No REQ: GNT = 0.
- On a grant to port g at the clock edge:
  - PTR <= (g+1) mod NUM_PORTS.
  - Next cycle: MEM_ADDR/MEM_D/MEM_BE = port g slices; MEM_WE = WE[g]; MEM_RE = ~WE[g]. The two strobes are never both 1.
- No grant: MEM_WE = MEM_RE = 0 next cycle. MEM_ADDR/MEM_D/MEM_BE hold their previous values.
- Throughput: one command per cycle; back-to-back grants allowed, including to the same port if it is the only requester.
- Lock:
  - A grant to g with LOCK[g]=1 sets lock owner = g.
  - While locked, only port g is eligible; other REQs wait.
  - Lock releases at the edge of a grant to g with LOCK[g]=0.
  - While locked, PTR does not advance; it updates on the releasing grant.
  - A locked owner dropping REQ keeps the lock; no timeout.
- Read return:
  - Tag pipeline of depth RD_LATENCY records the port id of each cycle with MEM_RE=1.
  - RVALID[id] = 1 exactly RD_LATENCY cycles after that MEM_RE cycle, for one cycle; RDATA = MEM_Q in that cycle.
  - Overall: grant in cycle t gives RVALID in cycle t+1+RD_LATENCY.
  - Writes produce no RVALID.
- Ordering: accesses reach memory in grant order. A read granted after a write to the same address returns the written data; the memory provides this.
- Simultaneous grant and return in the same cycle are independent; both occur.

Test Plan:
- Single read: port 1 REQ, WE=0, ADDR=0x10, RD_LATENCY=1, memory returns 0xCAFE -> GNT=0b0010 in cycle t; MEM_RE=1, MEM_ADDR=0x10 at t+1; RVALID=0b0010, RDATA=0xCAFE at t+2.
- All 4 ports request continuously from reset -> GNT sequence 0,1,2,3,0,1 on consecutive cycles, MEM_RE every cycle, RVALID follows the same order shifted by 2 cycles.
- Write then read: port 0 writes 0xDEADBEEF, BE=0xF to 0x40, then reads 0x40 -> MEM_WE=1 for one cycle with no RVALID; read returns 0xDEADBEEF on RVALID[0].
- Lock: port 2 issues 3 grants with LOCK=1,1,0 while port 0 requests continuously -> port 0 is not granted until the cycle after the LOCK=0 grant; PTR then points to 3, so port 0 is granted next.
- Pointer chase via port 3 (read 0 -> data 5 -> read (5+1)<<2 = 0x18) with port 1 writing in parallel -> port 3 reads return the correct chain values; writes are interleaved round-robin.
- Reset mid-read: RST asserted the cycle after MEM_RE=1 -> no RVALID ever appears for that read; all outputs 0; after RST release, the first grant goes to port 0 if requesting.
